// File: rtl/sigdelay_multitap.sv
// -----------------------------------------------------------------------------
// sigdelay_multitap
//
// Multi-tap signal delay line. Each accepted strobe writes one sample into a
// circular RAM. The block then reads NUM_TAPS delayed copies through a single
// read port, one tap per cycle, and publishes all taps together on dout.
//
// Optional build macro:
//   SIGDELAY_MIX_EN  defined   -> mix is the registered sum of all masked taps
//                    undefined -> no adder is built and mix is tied to zero
//
// Ports:
//   clk         system clock (single domain)
//   rst         synchronous active-high reset
//   en          sample strobe, accepted only while busy = 0
//   sample      input sample, captured on an accepted strobe
//   offsets     packed per-tap delay, tap i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dout        packed per-tap delayed samples, same packing as offsets
//   dout_valid  one-cycle pulse when dout/mix are updated
//   mix         unsigned sum of all taps (zero when SIGDELAY_MIX_EN is undefined)
//   busy        high while a tap read sequence is in progress
//   wr_addr     write pointer (next slot to be written)
//   overrun     sticky: a strobe arrived while busy; cleared only by rst
//
// Timing for a strobe accepted in cycle c0: busy is high in c1..c(NUM_TAPS+1),
// dout_valid and the new dout/mix appear in c(NUM_TAPS+2), where a new strobe
// can already be accepted.
// -----------------------------------------------------------------------------
module sigdelay_multitap #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_TAPS   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [DATA_WIDTH-1:0]                     sample,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0]            offsets,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]            dout,
  output logic                                      dout_valid,
  output logic [DATA_WIDTH+$clog2(NUM_TAPS)+1-1:0]  mix,
  output logic                                      busy,
  output logic [ADDR_WIDTH-1:0]                     wr_addr,
  output logic                                      overrun
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int FW    = ADDR_WIDTH + 1;                       // fill counts 0..DEPTH
  localparam int TIW   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int MW    = DATA_WIDTH + $clog2(NUM_TAPS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_s;

  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [FW-1:0]           fill_r;
  logic [FW-1:0]           fill_nxt_s;
  logic [ADDR_WIDTH-1:0]   off_r [NUM_TAPS];
  logic [NUM_TAPS-1:0]     mask_r;
  logic [TIW-1:0]          tap_idx_r;
  logic [DATA_WIDTH-1:0]   shadow_r [NUM_TAPS];
  logic [DATA_WIDTH-1:0]   tap_final_s [NUM_TAPS];

  logic [NUM_TAPS*DATA_WIDTH-1:0] dout_r;
  logic                    dout_valid_r;
  logic                    busy_r;
  logic                    overrun_r;

  logic                    accept_s;
  logic                    drop_s;
  logic                    issue_s;
  logic                    capture_s;
  logic                    done_s;
  logic                    last_tap_s;

  assign last_tap_s = (tap_idx_r == TIW'(NUM_TAPS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt_s = ST_READ;
        else    state_nxt_s = ST_IDLE;
      end
      ST_READ: begin
        if (last_tap_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_READ;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control decode
  always_comb begin
    accept_s  = 1'b0;
    drop_s    = 1'b0;
    issue_s   = 1'b0;
    capture_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = en & ~rst;
      end
      ST_READ: begin
        drop_s    = en;
        issue_s   = 1'b1;
        // tap i-1 arrives from the RAM while tap i's address is issued
        capture_s = (tap_idx_r != TIW'(0));
      end
      ST_DONE: begin
        drop_s = en;
        done_s = 1'b1;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Saturating fill count after the current write
  always_comb begin
    if (fill_r == FW'(DEPTH)) fill_nxt_s = fill_r;
    else                      fill_nxt_s = fill_r + FW'(1);
  end

  // Read address: walk backwards from the slot just written, wrapping mod DEPTH
  always_comb begin
    rd_addr_s = base_r - off_r[tap_idx_r];
  end

  // Final tap values; the last tap is taken straight from the RAM output so
  // all taps publish in the same cycle as its capture
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (mask_r[i]) begin
        tap_final_s[i] = '0;
      end else if (i == NUM_TAPS - 1) begin
        tap_final_s[i] = rd_data_r;
      end else begin
        tap_final_s[i] = shadow_r[i];
      end
    end
  end

  // Sample RAM: one write port, one synchronous read port, contents not reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem[wr_addr_r] <= sample;
    end
    rd_data_r <= mem[rd_addr_s];
  end

  // Sequencing registers, shadow capture and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_r    <= '0;
      base_r       <= '0;
      fill_r       <= '0;
      mask_r       <= '0;
      tap_idx_r    <= '0;
      busy_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_r       <= '0;
      overrun_r    <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        off_r[i]    <= '0;
        shadow_r[i] <= '0;
      end
    end else begin
      dout_valid_r <= done_s;
      if (accept_s) begin
        base_r    <= wr_addr_r;
        wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
        fill_r    <= fill_nxt_s;
        tap_idx_r <= '0;
        busy_r    <= 1'b1;
        for (int i = 0; i < NUM_TAPS; i++) begin
          off_r[i]  <= offsets[i*ADDR_WIDTH +: ADDR_WIDTH];
          // history older than what has been written since reset reads as 0
          mask_r[i] <= ({1'b0, offsets[i*ADDR_WIDTH +: ADDR_WIDTH]} >= fill_nxt_s);
        end
      end
      if (issue_s && !last_tap_s) begin
        tap_idx_r <= tap_idx_r + TIW'(1);
      end
      if (capture_s) begin
        shadow_r[tap_idx_r - TIW'(1)] <= rd_data_r;
      end
      if (done_s) begin
        shadow_r[NUM_TAPS-1] <= rd_data_r;
        busy_r               <= 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
          dout_r[i*DATA_WIDTH +: DATA_WIDTH] <= tap_final_s[i];
        end
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

`ifdef SIGDELAY_MIX_EN
  logic [MW-1:0] mix_r;
  logic [MW-1:0] mix_sum_s;

  // Zero-extended sum of the masked taps
  always_comb begin
    mix_sum_s = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      mix_sum_s = mix_sum_s + MW'(tap_final_s[i]);
    end
  end

  // Mix register, updated together with dout
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_r <= '0;
    end else if (done_s) begin
      mix_r <= mix_sum_s;
    end
  end

  assign mix = mix_r;
`else
  assign mix = MW'(0);
`endif

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign wr_addr    = wr_addr_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_sigdelay_multitap.sv
module tb_sigdelay_multitap;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NT = 2;
  localparam int DEPTH = 16;
  localparam int MW = DW + 1 + 1;

`ifdef SIGDELAY_MIX_EN
  localparam bit MIX_ON = 1'b1;
`else
  localparam bit MIX_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              en;
  logic [DW-1:0]     sample;
  logic [NT*AW-1:0]  offsets;
  logic [NT*DW-1:0]  dout;
  logic              dout_valid;
  logic [MW-1:0]     mix;
  logic              busy;
  logic [AW-1:0]     wr_addr;
  logic              overrun;

  int total;
  int bad;

  // reference model: full write history since reset
  logic [7:0] hist[$];
  logic [7:0] exp_d0, exp_d1;

  sigdelay_multitap #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample), .offsets(offsets),
    .dout(dout), .dout_valid(dout_valid), .mix(mix), .busy(busy),
    .wr_addr(wr_addr), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [3:0] o0;
    logic [3:0] o1;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [3:0] wa;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_tap(input int off);
    int n;
    int f;
    n = hist.size();
    f = (n > DEPTH) ? DEPTH : n;
    if (off >= f) return 8'h00;
    return hist[n - 1 - off];
  endfunction

  function automatic logic [31:0] model_mix(input logic [7:0] a, input logic [7:0] b);
    if (MIX_ON) return 32'(a) + 32'(b);
    return 32'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    hist.delete();
    exp_d0 = 8'h00;
    exp_d1 = 8'h00;
  endtask

  // One legal write; returns in the cycle dout_valid is high
  task automatic do_write(input logic [7:0] s, input logic [3:0] o0, input logic [3:0] o1,
                          output logic [7:0] g0, output logic [7:0] g1);
    int lat;
    en      = 1'b1;
    sample  = s;
    offsets = {o1, o0};
    hist.push_back(s);
    exp_d0 = model_tap(int'(o0));
    exp_d1 = model_tap(int'(o1));
    tick();
    en  = 1'b0;
    lat = 1;
    chk("busy_c1", 32'(busy), 32'd1);
    while (dout_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("tap0", 32'(dout[7:0]), 32'(exp_d0));
    chk("tap1", 32'(dout[15:8]), 32'(exp_d1));
    chk("mix", 32'(mix), model_mix(exp_d0, exp_d1));
    chk("wr_addr", 32'(wr_addr), 32'(hist.size() % DEPTH));
    chk("busy_done", 32'(busy), 32'd0);
    g0 = dout[7:0];
    g1 = dout[15:8];
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] g0, g1;
    int vcnt;
    logic [3:0] wa_before;

    total = 0;
    bad = 0;
    rst = 1'b0;
    en = 1'b0;
    sample = '0;
    offsets = '0;

    // ---- Test 1: reset state and a single write ----
    do_reset();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_mix", 32'(mix), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    do_write(8'h11, 4'd0, 4'd0, g0, g1);
    chk("t1_tap0", 32'(g0), 32'h11);
    chk("t1_tap1", 32'(g1), 32'h11);
    chk("t1_wr_addr", 32'(wr_addr), 32'd1);
    chk("t1_mix", 32'(mix), MIX_ON ? 32'h022 : 32'h0);
    tick();
    chk("t1_valid_pulse", 32'(dout_valid), 32'd0);
    chk("t1_hold", 32'(dout), 32'h1111);

    // ---- Test 2: delay and masking, back-to-back strobes ----
    tbl[0] = '{s: 8'h01, o0: 4'd0, o1: 4'd3, t0: 8'h01, t1: 8'h00, wa: 4'd1};
    tbl[1] = '{s: 8'h02, o0: 4'd0, o1: 4'd3, t0: 8'h02, t1: 8'h00, wa: 4'd2};
    tbl[2] = '{s: 8'h03, o0: 4'd0, o1: 4'd3, t0: 8'h03, t1: 8'h00, wa: 4'd3};
    tbl[3] = '{s: 8'h04, o0: 4'd0, o1: 4'd3, t0: 8'h04, t1: 8'h01, wa: 4'd4};
    tbl[4] = '{s: 8'h05, o0: 4'd0, o1: 4'd3, t0: 8'h05, t1: 8'h02, wa: 4'd5};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(tbl[i].s, tbl[i].o0, tbl[i].o1, g0, g1);
      chk("t2_tap0", 32'(g0), 32'(tbl[i].t0));
      chk("t2_tap1", 32'(g1), 32'(tbl[i].t1));
      chk("t2_wr_addr", 32'(wr_addr), 32'(tbl[i].wa));
    end

    // ---- Test 3: wrap-around ----
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      do_write(8'(i), 4'd0, 4'd15, g0, g1);
    end
    chk("t3_wr_addr", 32'(wr_addr), 32'd4);
    chk("t3_tap1", 32'(g1), 32'h05);
    chk("t3_tap0", 32'(g0), 32'h14);

    // ---- Test 4: overrun ----
    do_reset();
    wa_before = wr_addr;
    en = 1'b1;
    sample = 8'h5A;
    offsets = {4'd0, 4'd0};
    hist.push_back(8'h5A);
    tick();
    sample = 8'hC3;        // arrives while busy: must be dropped
    offsets = {4'd1, 4'd1};
    tick();
    en = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (dout_valid === 1'b1) begin
        vcnt++;
        chk("t4_tap0", 32'(dout[7:0]), 32'h5A);
        chk("t4_tap1", 32'(dout[15:8]), 32'h5A);
      end
      tick();
    end
    chk("t4_valid_count", 32'(vcnt), 32'd1);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_wr_addr", 32'(wr_addr), 32'(wa_before + 4'd1));
    do_write(8'h77, 4'd0, 4'd1, g0, g1);
    chk("t4_tap1_prev", 32'(g1), 32'h5A);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    do_reset();
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // ---- Test 5: reset mid-operation ----
    do_write(8'h21, 4'd0, 4'd0, g0, g1);
    en = 1'b1;
    sample = 8'hAA;
    offsets = {4'd0, 4'd0};
    tick();
    en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hist.delete();
    vcnt = 0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_wr_addr", 32'(wr_addr), 32'd0);
    chk("t5_dout", 32'(dout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (dout_valid === 1'b1) vcnt++;
      tick();
    end
    chk("t5_no_valid", 32'(vcnt), 32'd0);
    do_write(8'h33, 4'd1, 4'd1, g0, g1);
    chk("t5_masked0", 32'(g0), 32'h00);
    chk("t5_masked1", 32'(g1), 32'h00);
    // rst together with en: sample must not be written
    rst = 1'b1;
    en = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b0;
    hist.delete();
    tick();
    chk("t5_rst_en_wr", 32'(wr_addr), 32'd0);
    chk("t5_rst_en_busy", 32'(busy), 32'd0);

    // ---- Test 6: mix with full-scale taps ----
    do_reset();
    do_write(8'hFF, 4'd0, 4'd0, g0, g1);
    chk("t6_dout", 32'(dout), 32'hFFFF);
    chk("t6_mix", 32'(mix), MIX_ON ? 32'h1FE : 32'h0);

    // ---- Randomized writes against the model ----
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int gap;
      do_write(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), g0, g1);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        tick();
        chk("rnd_hold", 32'(dout), 32'({exp_d1, exp_d0}));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
